// File: rtl/demux_rr_sched.sv
// Round-robin 1-to-4 demux: latches one upstream beat and offers it to the next enabled channel.
// Optional per-channel delivered-beat counters are compiled in with DEMUX_SCHED_CNT_EN.
module demux_rr_sched #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        chan_en,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        cur_sel,
  output logic              busy,
  output logic [31:0]       beat_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]        r_state;
  logic [1:0]        r_ptr;
  logic [1:0]        r_sel;
  logic [DATA_W-1:0] r_data;

  logic       w_deliver;
  logic       w_ready;
  logic       w_accept;
  logic [1:0] w_base;
  logic [1:0] w_pick;

  // First enabled channel at or after base, searching cyclically; later offsets are
  // overwritten by nearer ones, so the closest match wins.
  function automatic logic [1:0] f_pick(input logic [1:0] base, input logic [3:0] en);
    logic [1:0] idx;
    f_pick = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (en[idx]) f_pick = idx;
    end
  endfunction

  always_comb begin
    w_deliver = (r_state == ST_HOLD) && out_ready[r_sel];
    w_ready   = (|chan_en) && ((r_state == ST_IDLE) || w_deliver);
    w_accept  = in_valid && w_ready;
    w_base    = (r_state == ST_HOLD) ? (r_sel + 2'd1) : r_ptr;
    w_pick    = f_pick(w_base, chan_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_sel   <= 2'd0;
      r_data  <= '0;
    end else begin
      if (w_deliver) r_ptr <= r_sel + 2'd1;
      if (w_accept) begin
        r_data  <= in_data;
        r_sel   <= w_pick;
        r_state <= ST_HOLD;
      end else if (w_deliver) begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = (r_state == ST_HOLD) ? (4'b0001 << r_sel) : 4'b0000;
  assign out_data  = r_data;
  assign cur_sel   = r_sel;
  assign busy      = (r_state == ST_HOLD);

`ifdef DEMUX_SCHED_CNT_EN
  logic [7:0] r_cnt [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= 8'd0;
    end else if (w_deliver) begin
      r_cnt[r_sel] <= r_cnt[r_sel] + 8'd1;
    end
  end

  assign beat_cnt = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`else
  assign beat_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_demux_rr_sched.sv
// Randomised plus directed bench for demux_rr_sched against a cycle-level behavioural model.
module tb_demux_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] chan_en;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic [1:0] cur_sel;
  logic       busy;
  logic [31:0] beat_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state
  bit         m_hold;
  int         m_ptr;
  int         m_sel;
  logic [7:0] m_data;
  int         m_cnt [4];

  demux_rr_sched #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .chan_en   (chan_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cur_sel   (cur_sel),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_hold = 1'b0;
    m_ptr  = 0;
    m_sel  = 0;
    m_data = 8'h00;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // Compare on the falling edge, then predict what the next rising edge will do.
  initial begin
    bit         n_hold;
    int         n_ptr, n_sel, base;
    logic [7:0] n_data;
    int         n_cnt [4];
    bit         deliver, rdy, accept;
    logic [3:0] exp_valid;
    logic [31:0] exp_cnt;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      deliver   = m_hold && out_ready[m_sel];
      rdy       = (chan_en != 4'b0) && (!m_hold || deliver);
      accept    = in_valid && rdy;
      exp_valid = m_hold ? 4'(1 << m_sel) : 4'b0000;
`ifdef DEMUX_SCHED_CNT_EN
      exp_cnt = {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
`else
      exp_cnt = 32'd0;
`endif
      check("in_ready",  32'(in_ready),  32'(rdy));
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("busy",      32'(busy),      32'(m_hold));
      check("cur_sel",   32'(cur_sel),   32'(m_sel));
      check("out_data",  32'(out_data),  32'(m_data));
      check("beat_cnt",  beat_cnt,       exp_cnt);

      n_hold = m_hold; n_ptr = m_ptr; n_sel = m_sel; n_data = m_data;
      for (int i = 0; i < 4; i++) n_cnt[i] = m_cnt[i];
      if (deliver) begin
        n_ptr = (m_sel + 1) % 4;
        n_cnt[m_sel] = (m_cnt[m_sel] + 1) % 256;
        n_hold = 1'b0;
      end
      if (accept) begin
        base = m_hold ? (m_sel + 1) % 4 : m_ptr;
        for (int k = 3; k >= 0; k--)
          if (chan_en[(base + k) % 4]) n_sel = (base + k) % 4;
        n_data = in_data;
        n_hold = 1'b1;
      end

      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
        m_hold = n_hold; m_ptr = n_ptr; m_sel = n_sel; m_data = n_data;
        for (int i = 0; i < 4; i++) m_cnt[i] = n_cnt[i];
      end
    end
  end

  // Drive one cycle's inputs just after the rising edge, return at the falling edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic [3:0] en, input logic [3:0] rdy);
    @(posedge clk);
    #1;
    rst_n     = r;
    in_valid  = v;
    in_data   = d;
    chan_en   = en;
    out_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]  rd;
    logic [31:0] exp_lo;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; chan_en = 4'h0; out_ready = 4'h0;
    repeat (2) @(negedge clk);
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_busy",  32'(busy),      32'h0);

    // Rotation across all four channels, back-to-back
    step(1, 1, 8'h11, 4'hF, 4'hF);
    check("rot_rdy0", 32'(in_ready), 32'h1);
    step(1, 1, 8'h22, 4'hF, 4'hF);
    check("rot_v0", 32'(out_valid), 32'h1); check("rot_d0", 32'(out_data), 32'h11);
    check("rot_rdy1", 32'(in_ready), 32'h1);
    step(1, 1, 8'h33, 4'hF, 4'hF);
    check("rot_v1", 32'(out_valid), 32'h2); check("rot_d1", 32'(out_data), 32'h22);
    step(1, 1, 8'h44, 4'hF, 4'hF);
    check("rot_v2", 32'(out_valid), 32'h4); check("rot_d2", 32'(out_data), 32'h33);
    check("rot_rdy3", 32'(in_ready), 32'h1);
    step(1, 0, 8'h00, 4'hF, 4'hF);
    check("rot_v3", 32'(out_valid), 32'h8); check("rot_d3", 32'(out_data), 32'h44);
    step(1, 0, 8'h00, 4'hF, 4'hF);
    check("rot_idle", 32'(out_valid), 32'h0);

    // Skip disabled channels: b, d, b
    step(1, 1, 8'hA1, 4'b1010, 4'hF);
    step(1, 1, 8'hA2, 4'b1010, 4'hF);
    check("skip_b", 32'(out_valid), 32'h2);
    step(1, 1, 8'hA3, 4'b1010, 4'hF);
    check("skip_d", 32'(out_valid), 32'h8);
    step(1, 0, 8'h00, 4'b1010, 4'hF);
    check("skip_b2", 32'(out_valid), 32'h2); check("skip_d2", 32'(out_data), 32'hA3);
    step(1, 0, 8'h00, 4'b1010, 4'hF);

    // Backpressure on channel c, then ptr lands on d
    step(1, 1, 8'hC5, 4'hF, 4'b1011);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 8'h5C, 4'hF, 4'b1011);
      check("bp_valid", 32'(out_valid), 32'h4);
      check("bp_data",  32'(out_data),  32'hC5);
      check("bp_rdy",   32'(in_ready),  32'h0);
    end
    step(1, 0, 8'h00, 4'hF, 4'hF);
    check("bp_deliver", 32'(out_valid), 32'h4);
    step(1, 1, 8'hD1, 4'hF, 4'hF);
    check("bp_idle", 32'(out_valid), 32'h0);
    step(1, 0, 8'h00, 4'hF, 4'hF);
    check("bp_ptr3", 32'(out_valid), 32'h8);
    step(1, 0, 8'h00, 4'hF, 4'hF);

    // Mask removed while holding a beat for channel a
    step(1, 1, 8'hE1, 4'hF, 4'h0);
    step(1, 0, 8'h00, 4'h0, 4'h0);
    check("mask_hold", 32'(out_valid), 32'h1); check("mask_rdy", 32'(in_ready), 32'h0);
    step(1, 0, 8'h00, 4'h0, 4'h1);
    check("mask_deliver", 32'(out_valid), 32'h1);
    step(1, 1, 8'h00, 4'h0, 4'hF);
    check("mask_idle", 32'(out_valid), 32'h0); check("mask_rdy0", 32'(in_ready), 32'h0);

    // Asynchronous reset in the middle of a held beat
    step(1, 1, 8'hB7, 4'hF, 4'h0);
    step(1, 0, 8'h00, 4'hF, 4'h0);
    check("rst_pre_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'h0);
    check("rst_async_busy",  32'(busy),      32'h0);
    check("rst_async_data",  32'(out_data),  32'h0);
    step(0, 0, 8'h00, 4'hF, 4'hF);
    step(1, 1, 8'h5A, 4'hF, 4'hF);
    step(1, 0, 8'h00, 4'hF, 4'hF);
    check("rst_first_a", 32'(out_valid), 32'h1); check("rst_first_d", 32'(out_data), 32'h5A);
    step(1, 0, 8'h00, 4'hF, 4'hF);

    // 256 deliveries to channel a wrap its counter
    step(0, 0, 8'h00, 4'h1, 4'hF);
    for (int i = 0; i < 256; i++) step(1, 1, 8'(i), 4'h1, 4'hF);
    step(1, 0, 8'h00, 4'h1, 4'hF);
`ifdef DEMUX_SCHED_CNT_EN
    exp_lo = 32'h0000_00FF;
`else
    exp_lo = 32'h0;
`endif
    check("cnt_255", beat_cnt, exp_lo);
    step(1, 0, 8'h00, 4'h1, 4'hF);
    check("cnt_wrap", beat_cnt, 32'h0);

    // Random traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      rd = 8'($urandom);
      step(($urandom_range(0, 149) != 0), 1'($urandom), rd,
           ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom), 4'($urandom));
    end
    step(1, 0, 8'h00, 4'h0, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/demux_rr_sched.md
DEMUX_RR_SCHED -- requirements
Module: demux_rr_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of the data word routed through the block.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the upstream beat is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts the upstream beat this cycle.
REQ-006 SHALL have port in_data, input, DATA_W bits: the upstream data.
REQ-007 SHALL have port chan_en, input, 4 bits: per-channel enable mask; bit0=a, bit1=b, bit2=c, bit3=d.
REQ-008 SHALL have port out_valid, output, 4 bits: one-hot valid for channels a..d.
REQ-009 SHALL have port out_ready, input, 4 bits: per-channel downstream ready.
REQ-010 SHALL have port out_data, output, DATA_W bits: the latched beat, shared by all channels.
REQ-011 SHALL have port cur_sel, output, 2 bits: the channel currently holding the beat.
REQ-012 SHALL have port busy, output, 1 bit: high while in state HOLD.
REQ-013 SHALL have port beat_cnt, output, 32 bits: four 8-bit delivered-beat counters; [7:0]=a ... [31:24]=d.

Function
REQ-014 SHALL implement a two-state FSM with states IDLE and HOLD.
REQ-015 SHALL keep a 2-bit round-robin pointer ptr and a registered target sel.
REQ-016 SHALL drive in_ready = |chan_en && (IDLE || (HOLD && out_ready[sel])).
REQ-017 SHALL treat a cycle with in_valid && in_ready as an accept, on which it SHALL:
  - latch in_data into out_data;
  - set sel = the first enabled channel at or after the base (ptr in IDLE, sel+1 mod 4 in HOLD), searching cyclically;
  - enter HOLD.
REQ-018 SHALL drive out_valid = one-hot(sel) in HOLD and 4'b0000 in IDLE; it SHALL be asserted on the cycle after the accept (latency 1).
REQ-019 SHALL treat a cycle in HOLD with out_ready[sel]=1 as a delivery, on which it SHALL set ptr = sel+1 mod 4.
REQ-020 On a delivery without a simultaneous accept, SHALL return to IDLE.
REQ-021 On a delivery with a simultaneous accept, SHALL stay in HOLD with the new sel and data (back-to-back, one beat per cycle).
REQ-022 SHALL ignore out_ready bits other than out_ready[sel].
REQ-023 SHALL hold out_data and sel stable while out_ready[sel]=0.
REQ-024 SHALL sample chan_en only at an accept; a channel deasserted in HOLD SHALL still receive its pending beat.
REQ-025 SHALL, when chan_en=4'b0000, hold in_ready=0; a pending beat in HOLD SHALL still complete.
REQ-026 SHALL wrap ptr 3 -> 0 and SHALL wrap each beat_cnt counter 255 -> 0.
REQ-027 SHALL drive cur_sel = sel and busy = (state==HOLD).

Reset
REQ-028 SHALL, while rst_n=0, immediately force: state IDLE, ptr 0, sel 0, out_data 0, out_valid 0, busy 0 and beat_cnt 0.
REQ-029 SHALL discard a beat pending in HOLD when reset asserts, without delivering it; the first beat after reset SHALL be accepted from IDLE.

Configuration
REQ-030 SHALL use macro DEMUX_SCHED_CNT_EN to compile the beat counters in or out.
REQ-031 With DEMUX_SCHED_CNT_EN defined, SHALL increment counter [sel] by 1 on each delivery.
REQ-032 With DEMUX_SCHED_CNT_EN undefined, SHALL drive beat_cnt to constant 0 and SHALL contain no counter registers.

Verification
REQ-033 Rotation: chan_en=4'hF, out_ready=4'hF, four beats 0x11,0x22,0x33,0x44 back-to-back -> out_valid 0001,0010,0100,1000 on consecutive cycles with the matching data, and in_ready stays high.
REQ-034 Skip: chan_en=4'b1010, three beats -> delivered to channels b, d, b.
REQ-035 Backpressure: sel=c and out_ready[2]=0 for 5 cycles -> out_data stable, in_ready=0; on out_ready[2]=1 -> delivery, ptr=3.
REQ-036 Mask change: in HOLD on channel a, chan_en is set to 0 -> beat still delivered to a, then in_ready=0.
REQ-037 Reset: rst_n pulled low mid-HOLD -> out_valid=0 and busy=0 asynchronously; after release, the next beat goes to channel a.
REQ-038 Counters (DEMUX_SCHED_CNT_EN defined): 256 deliveries to channel a -> beat_cnt[7:0] wraps to 0x00 and the other counters stay 0.
